data_mem_access_unit: RTL and testbench

- Executes the load/store commands that the control unit decodes.
- Consumes the MEM-stage main_mem_read/main_mem_write codes, address and store data.
- Performs byte, half and word accesses on a word-organised data memory with a wait-request handshake. Returns sign- or zero-extended load data.
- Holds BUSYWAIT high to stall the RV32IM pipeline until each access completes.

---
 rtl/data_mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_data_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - byte/half/word load-store executor for a word-organised data memory
// Optional wait-request timeout abort is built when DATA_MEM_TIMEOUT_EN is defined.
module data_mem_access_unit #(
   parameter int          MEM_ADDR_WIDTH = 10,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [3:0]                MAIN_MEM_READ,
   input  logic [2:0]                MAIN_MEM_WRITE,
   input  logic [31:0]               ADDRESS,
   input  logic [31:0]               WRITE_DATA,
   output logic [31:0]               READ_DATA,
   output logic                      BUSYWAIT,
   output logic                      MISALIGNED,
   output logic                      BUS_ERROR,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [MEM_ADDR_WIDTH-1:0] mem_address,
   output logic [3:0]                mem_byteenable,
   output logic [31:0]               mem_writedata,
   input  logic [31:0]               mem_readdata,
   input  logic                      mem_waitrequest
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t      r_state;
   logic        r_is_load;
   logic        r_unsigned;
   logic [1:0]  r_size;
   logic [1:0]  r_addr_lo;

   logic        w_store;
   logic        w_load;
   logic        w_req;
   logic        w_misaligned;
   logic        w_start;
   logic [1:0]  w_size;
   logic [3:0]  w_byteenable;
   logic [31:0] w_writedata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic        w_unused;

   // A store overrides a simultaneous load; size code 1x means a full word for both.
   assign w_store      = MAIN_MEM_WRITE[2];
   assign w_load       = MAIN_MEM_READ[3] & ~w_store;
   assign w_req        = w_store | w_load;
   assign w_size       = w_store ? MAIN_MEM_WRITE[1:0] : MAIN_MEM_READ[1:0];
   assign w_misaligned = ((w_size == 2'b01) & ADDRESS[0]) | (w_size[1] & (|ADDRESS[1:0]));
   assign w_start      = (r_state == S_IDLE) & w_req & ~w_misaligned;
   assign BUSYWAIT     = w_start | (r_state == S_ACCESS);

   assign w_unused = ^{ADDRESS[31:MEM_ADDR_WIDTH+2], TIMEOUT_CYCLES[0]};

   always_comb begin
      w_byteenable = 4'b1111;
      w_writedata  = WRITE_DATA;
      case (w_size)
         2'b00: begin
            w_byteenable = 4'b0001 << ADDRESS[1:0];
            w_writedata  = {4{WRITE_DATA[7:0]}};
         end
         2'b01: begin
            w_byteenable = ADDRESS[1] ? 4'b1100 : 4'b0011;
            w_writedata  = {2{WRITE_DATA[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_byte = mem_readdata[{r_addr_lo, 3'b000} +: 8];
   assign w_half = r_addr_lo[1] ? mem_readdata[31:16] : mem_readdata[15:0];

   always_comb begin
      w_load_data = mem_readdata;
      case (r_size)
         2'b00:   w_load_data = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load_data = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         default: ;
      endcase
   end

`ifdef DATA_MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] r_wait_cnt;
`else
   assign BUS_ERROR = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state        <= S_IDLE;
         r_is_load      <= 1'b0;
         r_unsigned     <= 1'b0;
         r_size         <= 2'b00;
         r_addr_lo      <= 2'b00;
         READ_DATA      <= '0;
         MISALIGNED     <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= '0;
         mem_writedata  <= '0;
`ifdef DATA_MEM_TIMEOUT_EN
         BUS_ERROR      <= 1'b0;
         r_wait_cnt     <= '0;
`endif
      end else begin
         MISALIGNED <= 1'b0;
`ifdef DATA_MEM_TIMEOUT_EN
         BUS_ERROR  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               MISALIGNED <= w_req & w_misaligned;
               if (w_start) begin
                  mem_read       <= w_load;
                  mem_write      <= w_store;
                  mem_address    <= ADDRESS[MEM_ADDR_WIDTH+1:2];
                  mem_byteenable <= w_byteenable;
                  mem_writedata  <= w_writedata;
                  r_is_load      <= w_load;
                  r_unsigned     <= MAIN_MEM_READ[2];
                  r_size         <= w_size;
                  r_addr_lo      <= ADDRESS[1:0];
`ifdef DATA_MEM_TIMEOUT_EN
                  r_wait_cnt     <= '0;
`endif
                  r_state        <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!mem_waitrequest) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (r_is_load) READ_DATA <= w_load_data;
                  r_state   <= S_DONE;
               end
`ifdef DATA_MEM_TIMEOUT_EN
               else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  BUS_ERROR <= 1'b1;
                  READ_DATA <= '0;
                  r_state   <= S_DONE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
`endif
            end
            // Requests still presented during DONE belong to the retiring instruction.
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb/tb_data_mem_access_unit.sv - self-checking bench for data_mem_access_unit
module tb_data_mem_access_unit;
   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  MAIN_MEM_READ;
   logic [2:0]  MAIN_MEM_WRITE;
   logic [31:0] ADDRESS;
   logic [31:0] WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT;
   logic        MISALIGNED;
   logic        BUS_ERROR;
   logic        mem_read;
   logic        mem_write;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;

   logic [31:0] mem_arr [0:1023];
   logic [7:0]  ref_mem [0:255];
   int          wait_cfg = 0;
   int          checks = 0;
   int          errors = 0;

   data_mem_access_unit dut (
      .CLK(CLK), .RESET(RESET),
      .MAIN_MEM_READ(MAIN_MEM_READ), .MAIN_MEM_WRITE(MAIN_MEM_WRITE),
      .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
      .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest)
   );

   initial forever #5 CLK = ~CLK;

   assign mem_readdata = mem_arr[mem_address];

   // Memory wait-request responder: each new access sees wait_cfg stalled cycles.
   initial begin
      int  wc;
      bit  prev;
      wc = 0;
      prev = 0;
      mem_waitrequest = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (mem_read || mem_write) begin
            if (!prev) wc = wait_cfg;
            else if (wc > 0) wc--;
            prev = 1;
         end else begin
            prev = 0;
            wc = 0;
         end
         mem_waitrequest = (wc > 0);
      end
   end

   typedef struct {
      logic [3:0]  rd;
      logic [2:0]  wr;
      logic [31:0] addr;
      logic [31:0] wd;
      int          waits;
      int          exp_busy;
      int          exp_strb;
      int          exp_mis;
      logic [3:0]  exp_be;
      logic [9:0]  exp_maddr;
      bit          chk_wd;
      logic [31:0] exp_wd;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   function automatic vec_t mk(logic [3:0] rd, logic [2:0] wr, logic [31:0] addr, logic [31:0] wd,
                               int waits, int busy, int strb, int mis, logic [3:0] be,
                               logic [9:0] maddr, bit chk_wd, logic [31:0] ewd, logic [31:0] erd);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.waits = waits;
      v.exp_busy = busy; v.exp_strb = strb; v.exp_mis = mis; v.exp_be = be;
      v.exp_maddr = maddr; v.chk_wd = chk_wd; v.exp_wd = ewd; v.exp_rdata = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic sample(inout int busy, inout int strb, inout int mis, inout int berr,
                         inout logic [3:0] be, inout logic [9:0] maddr, inout logic [31:0] mwd);
      if (BUSYWAIT) busy++;
      if (MISALIGNED) mis++;
      if (BUS_ERROR) berr++;
      if (mem_read || mem_write) begin
         strb++;
         be = mem_byteenable;
         maddr = mem_address;
         mwd = mem_writedata;
      end
      if (mem_write && !mem_waitrequest)
         for (int i = 0; i < 4; i++)
            if (mem_byteenable[i]) mem_arr[mem_address][8*i +: 8] = mem_writedata[8*i +: 8];
   endtask

   // Request is held through the DONE cycle, then dropped; two trailing cycles catch reissues.
   task automatic do_op(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits,
                        output int busy, output int strb, output int mis, output int berr,
                        output logic [3:0] be, output logic [9:0] maddr, output logic [31:0] mwd,
                        output logic [31:0] rdata);
      bit done;
      done = 0;
      busy = 0; strb = 0; mis = 0; berr = 0;
      be = '0; maddr = '0; mwd = '0;
      @(posedge CLK);
      #1;
      wait_cfg = waits;
      MAIN_MEM_READ = rd; MAIN_MEM_WRITE = wr; ADDRESS = addr; WRITE_DATA = wd;
      for (int n = 0; n < 64 && !done; n++) begin
         @(negedge CLK);
         sample(busy, strb, mis, berr, be, maddr, mwd);
         if (!BUSYWAIT) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL op_bound actual=busy_stuck required=release_within_64");
      end
      rdata = READ_DATA;
      @(posedge CLK);
      #1;
      MAIN_MEM_READ = '0; MAIN_MEM_WRITE = '0;
      repeat (2) begin
         @(negedge CLK);
         sample(busy, strb, mis, berr, be, maddr, mwd);
      end
   endtask

   initial begin
      int          busy, strb, mis, berr;
      logic [3:0]  be;
      logic [9:0]  maddr;
      logic [31:0] mwd, rdata;
      logic [31:0] model_rdata;

      for (int w = 0; w < 1024; w++) mem_arr[w] = '0;
      mem_arr[4] = 32'h80F0_7F01;

      vecs[0]  = mk(4'b1000, 3'b000, 32'h11, 32'h0, 0, 2, 1, 0, 4'b0010, 10'd4, 0, 32'h0, 32'h0000_007F);
      vecs[1]  = mk(4'b1000, 3'b000, 32'h12, 32'h0, 0, 2, 1, 0, 4'b0100, 10'd4, 0, 32'h0, 32'hFFFF_FFF0);
      vecs[2]  = mk(4'b1100, 3'b000, 32'h13, 32'h0, 0, 2, 1, 0, 4'b1000, 10'd4, 0, 32'h0, 32'h0000_0080);
      vecs[3]  = mk(4'b1001, 3'b000, 32'h12, 32'h0, 0, 2, 1, 0, 4'b1100, 10'd4, 0, 32'h0, 32'hFFFF_80F0);
      vecs[4]  = mk(4'b1101, 3'b000, 32'h12, 32'h0, 0, 2, 1, 0, 4'b1100, 10'd4, 0, 32'h0, 32'h0000_80F0);
      vecs[5]  = mk(4'b1010, 3'b000, 32'h10, 32'h0, 2, 4, 3, 0, 4'b1111, 10'd4, 0, 32'h0, 32'h80F0_7F01);
      vecs[6]  = mk(4'b1011, 3'b000, 32'h10, 32'h0, 0, 2, 1, 0, 4'b1111, 10'd4, 0, 32'h0, 32'h80F0_7F01);
      vecs[7]  = mk(4'b1010, 3'b110, 32'h10, 32'hDEAD_BEEF, 0, 2, 1, 0, 4'b1111, 10'd4, 1, 32'hDEAD_BEEF, 32'h80F0_7F01);
      vecs[8]  = mk(4'b1010, 3'b000, 32'h10, 32'h0, 1, 3, 2, 0, 4'b1111, 10'd4, 0, 32'h0, 32'hDEAD_BEEF);
      vecs[9]  = mk(4'b0000, 3'b100, 32'h13, 32'h0000_00AB, 0, 2, 1, 0, 4'b1000, 10'd4, 1, 32'hABAB_ABAB, 32'hDEAD_BEEF);
      vecs[10] = mk(4'b0000, 3'b101, 32'h12, 32'h0000_1234, 0, 2, 1, 0, 4'b1100, 10'd4, 1, 32'h1234_1234, 32'hDEAD_BEEF);
      vecs[11] = mk(4'b1010, 3'b000, 32'h10, 32'h0, 3, 5, 4, 0, 4'b1111, 10'd4, 0, 32'h0, 32'h1234_BEEF);
      vecs[12] = mk(4'b1010, 3'b000, 32'h16, 32'h0, 0, 0, 0, 1, 4'b0000, 10'd0, 0, 32'h0, 32'h1234_BEEF);
      vecs[13] = mk(4'b1001, 3'b000, 32'h13, 32'h0, 0, 0, 0, 1, 4'b0000, 10'd0, 0, 32'h0, 32'h1234_BEEF);
      vecs[14] = mk(4'b0000, 3'b111, 32'h18, 32'h0BAD_F00D, 0, 2, 1, 0, 4'b1111, 10'd6, 1, 32'h0BAD_F00D, 32'h1234_BEEF);
      vecs[15] = mk(4'b1101, 3'b000, 32'h1A, 32'h0, 0, 2, 1, 0, 4'b1100, 10'd6, 0, 32'h0, 32'h0000_0BAD);
      vecs[16] = mk(4'b1000, 3'b000, 32'h18, 32'h0, 0, 2, 1, 0, 4'b0001, 10'd6, 0, 32'h0, 32'h0000_000D);

      RESET = 1'b1;
      MAIN_MEM_READ = '0; MAIN_MEM_WRITE = '0; ADDRESS = '0; WRITE_DATA = '0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
      chk("rst_read_data", READ_DATA, 32'd0);
      chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      chk("rst_pulses", {30'b0, MISALIGNED, BUS_ERROR}, 32'd0);
      chk("rst_mem_address", {22'b0, mem_address}, 32'd0);
      chk("rst_byteenable", {28'b0, mem_byteenable}, 32'd0);
      chk("rst_writedata", mem_writedata, 32'd0);

      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits,
               busy, strb, mis, berr, be, maddr, mwd, rdata);
         chk($sformatf("vec%0d_busy_cycles", i), busy, vecs[i].exp_busy);
         chk($sformatf("vec%0d_strobe_cycles", i), strb, vecs[i].exp_strb);
         chk($sformatf("vec%0d_misaligned", i), mis, vecs[i].exp_mis);
         chk($sformatf("vec%0d_bus_error", i), berr, 32'd0);
         chk($sformatf("vec%0d_read_data", i), rdata, vecs[i].exp_rdata);
         if (vecs[i].exp_strb > 0) begin
            chk($sformatf("vec%0d_byteenable", i), {28'b0, be}, {28'b0, vecs[i].exp_be});
            chk($sformatf("vec%0d_mem_address", i), {22'b0, maddr}, {22'b0, vecs[i].exp_maddr});
         end
         if (vecs[i].chk_wd) chk($sformatf("vec%0d_writedata", i), mwd, vecs[i].exp_wd);
      end

      // Reset while an access is stalled by a stuck wait-request.
      @(posedge CLK);
      #1;
      wait_cfg = 1000;
      MAIN_MEM_READ = 4'b1010; ADDRESS = 32'h10;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("stall_mem_read", {31'b0, mem_read}, 32'd1);
      chk("stall_busywait", {31'b0, BUSYWAIT}, 32'd1);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      MAIN_MEM_READ = '0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      chk("midrst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      chk("midrst_busywait", {31'b0, BUSYWAIT}, 32'd0);
      chk("midrst_read_data", READ_DATA, 32'd0);
      wait_cfg = 0;

      for (int w = 0; w < 1024; w++) mem_arr[w] = '0;
      for (int w = 0; w < 64; w++) begin
         logic [31:0] v;
         v = $urandom;
         mem_arr[w] = v;
         for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
      end
      model_rdata = 32'd0;

      for (int t = 0; t < 200; t++) begin
         logic [3:0]  rd;
         logic [2:0]  wr;
         logic [31:0] addr, wd, val;
         int          waits, nb, sz;
         bit          is_store, aligned;
         rd = 4'($urandom);
         wr = 3'($urandom);
         if (!rd[3] && !wr[2]) rd[3] = 1'b1;
         addr = $urandom_range(0, 63);
         wd = $urandom;
         waits = $urandom_range(0, 3);
         is_store = wr[2];
         sz = is_store ? int'(wr[1:0]) : int'(rd[1:0]);
         nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
         aligned = (addr % nb) == 0;
         if (aligned && is_store) begin
            for (int b = 0; b < nb; b++) ref_mem[addr + b] = wd[8*b +: 8];
         end else if (aligned) begin
            val = 32'd0;
            for (int b = 0; b < nb; b++) val = val | ({24'b0, ref_mem[addr + b]} << (8*b));
            if (!rd[2] && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
            model_rdata = val;
         end
         do_op(rd, wr, addr, wd, waits, busy, strb, mis, berr, be, maddr, mwd, rdata);
         chk($sformatf("rnd%0d_busy_cycles", t), busy, aligned ? 2 + waits : 0);
         chk($sformatf("rnd%0d_strobe_cycles", t), strb, aligned ? 1 + waits : 0);
         chk($sformatf("rnd%0d_misaligned", t), mis, aligned ? 0 : 1);
         chk($sformatf("rnd%0d_read_data", t), rdata, model_rdata);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
